// File: rtl/pfifo_sync.sv
// Synchronous FIFO with power-of-two depth, selectable registered or fall-through read,
// occupancy flags derived from a registered count, and sticky overflow/underflow flags.
module pfifo_sync #(
  parameter int D_WIDTH  = 8,
  parameter int ADDRS    = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = (2 ** ADDRS) - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               rd_valid,
  input  logic               err_clr,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [ADDRS:0]     count,
  output logic               overflow,
  output logic               underflow
);

  localparam int DEPTH = 2 ** ADDRS;
  localparam int CNT_W = ADDRS + 1;

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDRS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDRS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               push_ok_s, pop_ok_s;

  // Flags depend only on the registered count, never on the request inputs.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == CNT_W'(0));
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    push_ok_s   = wr_en & ~full;
    pop_ok_s    = rd_en & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + ADDRS'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + ADDRS'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A new error event wins over a coincident clear.
    if (wr_en & full) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (rd_en & empty) begin
      underflow_d = 1'b1;
    end else if (err_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not cleared by reset; a push in a reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (!rst && push_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [D_WIDTH-1:0] rd_data_q, rd_data_d;
      logic               rd_valid_q, rd_valid_d;

      // Registered read: head word appears one cycle after an accepted pop.
      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (pop_ok_s) begin
          rd_data_d  = mem_q[rd_ptr_q];
          rd_valid_d = 1'b1;
        end else begin
          rd_data_d  = rd_data_q;
          rd_valid_d = 1'b0;
        end
      end

      // Read output registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft_read
      // Fall-through: head word is visible whenever the FIFO holds data.
      assign rd_valid = ~empty;
      assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    end
  endgenerate

endmodule

// File: tb/tb_pfifo_sync.sv
// Directed self-checking bench for pfifo_sync: one registered-read instance and one
// fall-through instance sharing clock and reset.
module tb_pfifo_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en0, rd_en0, err_clr0;
  logic [7:0] wr_data0, rd_data0;
  logic       rd_valid0, full0, empty0, af0, ae0, ovf0, udf0;
  logic [4:0] count0;
  logic       wr_en1, rd_en1, err_clr1;
  logic [7:0] wr_data1, rd_data1;
  logic       rd_valid1, full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0] count1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pfifo_sync #(.D_WIDTH(8), .ADDRS(4), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .err_clr(err_clr0), .full(full0),
    .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0)
  );

  pfifo_sync #(.D_WIDTH(8), .ADDRS(4), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .err_clr(err_clr1), .full(full1),
    .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wr_en0 = 1'b0; rd_en0 = 1'b0; err_clr0 = 1'b0; wr_data0 = 8'h00;
    wr_en1 = 1'b0; rd_en1 = 1'b0; err_clr1 = 1'b0; wr_data1 = 8'h00;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check_val("rst_count", count0, 64'd0);
    check_val("rst_empty", empty0, 64'd1);
    check_val("rst_ae", ae0, 64'd1);
    check_val("rst_full", full0, 64'd0);
    check_val("rst_af", af0, 64'd0);
    check_val("rst_rd_valid", rd_valid0, 64'd0);
    check_val("rst_rd_data", rd_data0, 64'd0);
    check_val("rst_ovf", ovf0, 64'd0);
    check_val("rst_udf", udf0, 64'd0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wr_en0 = 1'b1; wr_data0 = 8'(i);
      step();
      check_val("fill_count", count0, 64'(i + 1));
      check_val("fill_af", af0, (i + 1 >= 14) ? 64'd1 : 64'd0);
      check_val("fill_ae", ae0, (i + 1 <= 1) ? 64'd1 : 64'd0);
      check_val("fill_full", full0, (i == 15) ? 64'd1 : 64'd0);
    end
    wr_data0 = 8'hAA;
    step();
    check_val("ovf_count", count0, 64'd16);
    check_val("ovf_flag", ovf0, 64'd1);
    wr_en0 = 1'b0;
    step();
    check_val("ovf_sticky", ovf0, 64'd1);
    err_clr0 = 1'b1;
    step();
    err_clr0 = 1'b0;
    check_val("ovf_clr", ovf0, 64'd0);

    // Drain: each word one cycle after its pop
    for (int i = 0; i < 16; i++) begin
      rd_en0 = 1'b1;
      step();
      check_val("drain_valid", rd_valid0, 64'd1);
      check_val("drain_data", rd_data0, 64'(i));
      check_val("drain_count", count0, 64'(15 - i));
    end
    step();
    check_val("udf_flag", udf0, 64'd1);
    check_val("udf_valid", rd_valid0, 64'd0);
    check_val("udf_hold", rd_data0, 64'h0F);
    rd_en0 = 1'b0; err_clr0 = 1'b1;
    step();
    err_clr0 = 1'b0;
    check_val("udf_clr", udf0, 64'd0);

    // Wrap: 10 pushes, 10 pops
    for (int i = 0; i < 10; i++) begin
      wr_en0 = 1'b1; wr_data0 = 8'h20 + 8'(i);
      step();
    end
    wr_en0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_en0 = 1'b1;
      step();
      check_val("wrap_data", rd_data0, 64'h20 + 64'(i));
    end
    rd_en0 = 1'b0;
    check_val("wrap_count0", count0, 64'd0);
    // 12 pushes / 12 pops overlapped across the pointer wrap
    wr_en0 = 1'b1; wr_data0 = 8'h40;
    step();
    for (int i = 0; i < 11; i++) begin
      wr_en0 = 1'b1; wr_data0 = 8'h41 + 8'(i); rd_en0 = 1'b1;
      step();
      check_val("conc_data", rd_data0, 64'h40 + 64'(i));
      check_val("conc_count", count0, 64'd1);
    end
    wr_en0 = 1'b0;
    step();
    rd_en0 = 1'b0;
    check_val("conc_last", rd_data0, 64'h4B);
    check_val("conc_count_end", count0, 64'd0);
    check_val("conc_udf", udf0, 64'd0);

    // Full boundary: push+pop while full only pops
    for (int i = 0; i < 16; i++) begin
      wr_en0 = 1'b1; wr_data0 = 8'h60 + 8'(i);
      step();
    end
    rd_en0 = 1'b1; wr_data0 = 8'hEE;
    step();
    wr_en0 = 1'b0;
    check_val("full_both_count", count0, 64'd15);
    check_val("full_both_ovf", ovf0, 64'd1);
    check_val("full_both_data", rd_data0, 64'h60);
    for (int i = 0; i < 8; i++) begin
      step();
    end
    rd_en0 = 1'b0;
    check_val("mid_count", count0, 64'd7);
    check_val("mid_ovf", ovf0, 64'd1);

    // Reset mid-operation with a push request
    rst = 1'b1; wr_en0 = 1'b1; wr_data0 = 8'h99;
    step();
    rst = 1'b0; wr_en0 = 1'b0;
    check_val("mrst_count", count0, 64'd0);
    check_val("mrst_empty", empty0, 64'd1);
    check_val("mrst_ovf", ovf0, 64'd0);
    check_val("mrst_valid", rd_valid0, 64'd0);
    check_val("mrst_data", rd_data0, 64'd0);

    // Empty boundary: push+pop while empty only pushes
    wr_en0 = 1'b1; rd_en0 = 1'b1; wr_data0 = 8'h77;
    step();
    wr_en0 = 1'b0;
    check_val("empty_both_count", count0, 64'd1);
    check_val("empty_both_udf", udf0, 64'd1);
    check_val("empty_both_valid", rd_valid0, 64'd0);
    step();
    check_val("empty_both_data", rd_data0, 64'h77);
    check_val("empty_both_cnt0", count0, 64'd0);
    // Error coincident with clear keeps the flag
    err_clr0 = 1'b1;
    step();
    check_val("udf_coincident", udf0, 64'd1);
    rd_en0 = 1'b0;
    step();
    err_clr0 = 1'b0;
    check_val("udf_cleared", udf0, 64'd0);

    // Fall-through instance
    check_val("fwft_idle_valid", rd_valid1, 64'd0);
    wr_en1 = 1'b1; wr_data1 = 8'h5A;
    step();
    check_val("fwft_valid", rd_valid1, 64'd1);
    check_val("fwft_data", rd_data1, 64'h5A);
    wr_data1 = 8'h5B;
    step();
    wr_en1 = 1'b0;
    check_val("fwft_head_hold", rd_data1, 64'h5A);
    check_val("fwft_count", count1, 64'd2);
    rd_en1 = 1'b1;
    step();
    check_val("fwft_next_valid", rd_valid1, 64'd1);
    check_val("fwft_next_data", rd_data1, 64'h5B);
    step();
    rd_en1 = 1'b0;
    check_val("fwft_drained", rd_valid1, 64'd0);
    check_val("fwft_empty", empty1, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
